// File: rtl/tr_pkg.sv
// Shared types and helpers for the TR mode selector.
package tr_pkg;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      DRAIN  = 2'd1,
      DEAD   = 2'd2
   } tr_state_e;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_AUTO   = 1'b1;

   // Zero stays zero (drive off); small nonzero periods are raised to the minimum.
   function automatic logic [31:0] clamp_period(input logic [31:0] p, input logic [31:0] pmin);
      if (p == 32'd0) begin
         return 32'd0;
      end else if (p < pmin) begin
         return pmin;
      end else begin
         return p;
      end
   endfunction

endpackage

// File: rtl/tr_mode_ch.sv
// One TR channel: source mux, drain/dead-time changeover FSM and registered outputs.
module tr_mode_ch
   import tr_pkg::*;
#(
   parameter int unsigned WIDTH_TR   = 16,
   parameter int unsigned PERIOD_MIN = 4,
   parameter int unsigned DEAD_CYC   = 64,
   parameter int unsigned DRAIN_TO   = 4096
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                auto,
   input  logic                dir_auto,
   input  logic                dir_manual,
   input  logic                enable_auto,
   input  logic                enable_manual,
   input  logic                count_manual,
   input  logic [WIDTH_TR-1:0] period_auto,
   input  logic [WIDTH_TR-1:0] period_manual,
   input  logic                pulse_busy,
   output logic                drv_en,
   output logic                dir,
   output logic                counter_en,
   output logic [WIDTH_TR-1:0] period,
   output logic                mode,
   output logic                switching
);

   localparam int unsigned CNT_MAX = (DEAD_CYC > DRAIN_TO) ? DEAD_CYC : DRAIN_TO;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYC - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TO - 1);

   tr_state_e          state;
   logic [CNT_W-1:0]   cnt;

   logic                sel_dir;
   logic                tgt_dir;
   logic                tgt_en;
   logic                tgt_cnt_en;
   logic [WIDTH_TR-1:0] tgt_period;
   logic [WIDTH_TR-1:0] tgt_period_clamped;

   // sel_dir follows the applied mode for change detection; tgt_* follows the request.
   // In a steady ACTIVE cycle auto == mode, so tgt_* is also the applied source.
   always_comb begin
      sel_dir            = (mode == MODE_AUTO) ? dir_auto : dir_manual;
      tgt_dir            = auto ? dir_auto : dir_manual;
      tgt_en             = auto ? enable_auto : enable_manual;
      tgt_period         = auto ? period_auto : period_manual;
      tgt_cnt_en         = (auto == MODE_MANUAL) ? count_manual : 1'b0;
      tgt_period_clamped = WIDTH_TR'(clamp_period(32'(tgt_period), PERIOD_MIN));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= DEAD;
         cnt        <= '0;
         mode       <= MODE_MANUAL;
         dir        <= 1'b0;
         drv_en     <= 1'b0;
         counter_en <= 1'b0;
         period     <= '0;
         switching  <= 1'b1;
      end else begin
         unique case (state)
            ACTIVE: begin
               if ((auto != mode) || (sel_dir != dir)) begin
                  state      <= DRAIN;
                  cnt        <= '0;
                  drv_en     <= 1'b0;
                  counter_en <= 1'b0;
                  switching  <= 1'b1;
               end else begin
                  period     <= tgt_period_clamped;
                  drv_en     <= tgt_en & (tgt_period != '0);
                  counter_en <= tgt_cnt_en;
               end
            end
            DRAIN: begin
               if (!pulse_busy || (cnt == DRAIN_LAST)) begin
                  state <= DEAD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DEAD: begin
               if (cnt == DEAD_LAST) begin
                  // Direction and drive enable land on the same edge.
                  state      <= ACTIVE;
                  cnt        <= '0;
                  mode       <= auto;
                  dir        <= tgt_dir;
                  period     <= tgt_period_clamped;
                  drv_en     <= tgt_en & (tgt_period != '0);
                  counter_en <= tgt_cnt_en;
                  switching  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= DEAD;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/tr_mode_sel_mc.sv
// N-channel AUTO/MANUAL source selector: one tr_mode_ch per channel plus bus slicing.
module tr_mode_sel_mc
   import tr_pkg::*;
#(
   parameter int unsigned NCH        = 2,
   parameter int unsigned WIDTH_TR   = 16,
   parameter int unsigned PERIOD_MIN = 4,
   parameter int unsigned DEAD_CYC   = 64,
   parameter int unsigned DRAIN_TO   = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NCH-1:0]          auto,
   input  logic [NCH-1:0]          dir_AUTO,
   input  logic [NCH-1:0]          dir_MANUAL,
   input  logic [NCH-1:0]          enable_AUTO,
   input  logic [NCH-1:0]          enable_MANUAL,
   input  logic [NCH-1:0]          count_MANUAL,
   input  logic [NCH*WIDTH_TR-1:0] period_AUTO,
   input  logic [NCH*WIDTH_TR-1:0] period_MANUAL,
   input  logic [NCH-1:0]          pulse_busy,
   output logic [NCH-1:0]          drv_en_TR,
   output logic [NCH-1:0]          dir_TR,
   output logic [NCH-1:0]          counter_en_TR,
   output logic [NCH*WIDTH_TR-1:0] period_TR,
   output logic [NCH-1:0]          mode_TR,
   output logic [NCH-1:0]          switching
);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      tr_mode_ch #(
         .WIDTH_TR   (WIDTH_TR),
         .PERIOD_MIN (PERIOD_MIN),
         .DEAD_CYC   (DEAD_CYC),
         .DRAIN_TO   (DRAIN_TO)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .auto          (auto[i]),
         .dir_auto      (dir_AUTO[i]),
         .dir_manual    (dir_MANUAL[i]),
         .enable_auto   (enable_AUTO[i]),
         .enable_manual (enable_MANUAL[i]),
         .count_manual  (count_MANUAL[i]),
         .period_auto   (period_AUTO[i*WIDTH_TR +: WIDTH_TR]),
         .period_manual (period_MANUAL[i*WIDTH_TR +: WIDTH_TR]),
         .pulse_busy    (pulse_busy[i]),
         .drv_en        (drv_en_TR[i]),
         .dir           (dir_TR[i]),
         .counter_en    (counter_en_TR[i]),
         .period        (period_TR[i*WIDTH_TR +: WIDTH_TR]),
         .mode          (mode_TR[i]),
         .switching     (switching[i])
      );
   end

endmodule
